// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder_pkg
// Purpose  : Shared types and constants for the MEM-stage data-memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_responder_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Word-address width for a power-of-two DEPTH
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder_if
// Purpose  : MEM-stage request/response bus between pipeline and data memory.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    logic              req_valid;
    logic              req_write;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              stall;
    logic              resp_valid;
    logic [WORD_W-1:0] resp_rdata;
    logic              resp_err;
    logic              busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  stall, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output stall, resp_valid, resp_rdata, resp_err, busy
    );

endinterface
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Purpose  : Single-port word RAM with registered read; contents survive reset.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  wire logic              clk,
    input  wire logic              we,
    input  wire logic [ADDR_W-1:0] waddr,
    input  wire logic [WORD_W-1:0] wdata,
    input  wire logic [ADDR_W-1:0] raddr,
    output logic      [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        rdata <= r_mem[raddr];
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Fixed-latency data-memory responder that stalls the pipeline
//            until each load/store completes.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 3
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    dmem_responder_if.slave  bus
);

    localparam int         c_addrW   = clog2(DEPTH);
    localparam logic [3:0] c_cntInit = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_write;
    logic              r_err;
    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic [WORD_W-1:0] r_rdataHold;

    logic              w_curWrite;
    logic [WORD_W-1:0] w_curAddr;
    logic [WORD_W-1:0] w_curWdata;
    logic              w_curErr;
    logic              w_enterResp;
    logic              w_we;
    logic [WORD_W-1:0] w_ramRdata;
    logic [WORD_W-1:0] w_respData;

    // In IDLE the live request is used so a single-cycle latency can commit at acceptance
    always_comb begin
        w_curWrite = r_write;
        w_curAddr  = r_addr;
        w_curWdata = r_wdata;
        if (r_state == IDLE) begin
            w_curWrite = bus.req_write;
            w_curAddr  = bus.req_addr;
            w_curWdata = bus.req_wdata;
        end
    end

    assign w_curErr    = (w_curAddr[1:0] != 2'b00) ||
                         ({2'b00, w_curAddr[WORD_W-1:2]} >= 32'(DEPTH));
    assign w_enterResp = ((r_state == IDLE) && bus.req_valid && (LATENCY == 1)) ||
                         ((r_state == WAIT) && (r_cnt == 4'd0));
    // A reset landing on the commit edge must not let the store through
    assign w_we        = w_enterResp && w_curWrite && !w_curErr && rst_n;

    dmem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (c_addrW)
    ) u_array (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_curAddr[c_addrW+1:2]),
        .wdata (w_curWdata),
        .raddr (w_curAddr[c_addrW+1:2]),
        .rdata (w_ramRdata)
    );

    assign w_respData     = (r_write || r_err) ? '0 : w_ramRdata;

    assign bus.stall      = ((r_state == IDLE) && bus.req_valid) || (r_state == WAIT);
    assign bus.resp_valid = (r_state == RESP);
    assign bus.resp_err   = (r_state == RESP) && r_err;
    assign bus.busy       = (r_state != IDLE);
    assign bus.resp_rdata = (r_state == RESP) ? w_respData : r_rdataHold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_write     <= 1'b0;
            r_err       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdataHold <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_write <= bus.req_write;
                        r_addr  <= bus.req_addr;
                        r_wdata <= bus.req_wdata;
                        r_err   <= w_curErr;
                        if (LATENCY == 1) begin
                            r_state <= RESP;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= c_cntInit;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_rdataHold <= w_respData;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
